// File: rtl/layer_header_pkg.sv
// Layer header store layout and sequencer state encoding.
package layer_header_pkg;

  // Register indices within one layer header
  localparam logic [2:0] REG_FLAGS  = 3'd0;
  localparam logic [2:0] REG_WIDTH  = 3'd1;
  localparam logic [2:0] REG_HEIGHT = 3'd2;
  localparam logic [2:0] REG_XPOS   = 3'd3;
  localparam logic [2:0] REG_YPOS   = 3'd4;
  localparam logic [2:0] REG_XVEL   = 3'd5;
  localparam logic [2:0] REG_YVEL   = 3'd6;
  localparam logic [2:0] REG_FRAME  = 3'd7;

  // Bit positions within the FLAGS register
  localparam int unsigned FLAG_POPULATED = 0;
  localparam int unsigned FLAG_SPRITE    = 1;
  localparam int unsigned FLAG_HIDDEN    = 2;
  localparam int unsigned FLAG_ANIMATED  = 3;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_RD_FLAGS,
    ST_RD_XPOS,
    ST_RD_XVEL,
    ST_WR_XPOS,
    ST_RD_YPOS,
    ST_RD_YVEL,
    ST_WR_YPOS,
    ST_RD_FRAME,
    ST_WR_FRAME,
    ST_DONE
  } seq_state_e;

endpackage

// File: rtl/layer_update_alu.sv
// Combinational update arithmetic: position += velocity >>> VEL_SHIFT,
// and animation frame advance with wrap to zero.
module layer_update_alu #(
  parameter int unsigned VEL_SHIFT = 6
) (
  input  logic [15:0] pos_i,
  input  logic [15:0] vel_i,
  input  logic [15:0] frame_i,
  output logic [15:0] pos_o,
  output logic [15:0] frame_o
);

  logic signed [15:0] vel_shifted;
  logic [7:0]         num;
  logic [7:0]         cur;
  logic [8:0]         cur_inc;

  // Wrapping 16-bit position update and frame counter advance
  always_comb begin
    vel_shifted = $signed(vel_i) >>> VEL_SHIFT;
    pos_o       = pos_i + $unsigned(vel_shifted);

    num     = frame_i[7:0];
    cur     = frame_i[15:8];
    // 9-bit increment so cur=255 still compares as past the end
    cur_inc = {1'b0, cur} + 9'd1;
    if ((num <= 8'd1) || (cur_inc >= {1'b0, num})) begin
      frame_o = {8'h00, num};
    end else begin
      frame_o = {cur_inc[7:0], num};
    end
  end

endmodule

// File: rtl/layer_motion_sequencer.sv
// Per-frame layer sweep: applies sprite velocity and animation advance through
// the header store controller port, sharing that port with host accesses.
module layer_motion_sequencer
  import layer_header_pkg::*;
#(
  parameter int unsigned NUM_LAYERS = 32,
  parameter int unsigned LAYER_BITS = 5,
  parameter int unsigned VEL_SHIFT  = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frameStart,
  input  logic                  hostReq,
  input  logic                  hostWriteEn,
  input  logic [LAYER_BITS-1:0] hostLayer,
  input  logic [2:0]            hostRegIndex,
  input  logic [15:0]           hostWriteData,
  output logic                  hostGrant,
  output logic [15:0]           hostReadData,
  input  logic [15:0]           ctrlReadData,
  output logic [LAYER_BITS-1:0] ctrlReadWriteLayer,
  output logic [2:0]            layerRegisterIndex,
  output logic [15:0]           writeLayerData,
  output logic                  writeLayerEn,
  output logic                  busy,
  output logic                  sweepDone,
  output logic                  overrun
);

  seq_state_e            state_q, state_d;
  logic [LAYER_BITS-1:0] layer_q, layer_d;
  logic                  anim_q, anim_d;
  logic [15:0]           data_q, data_d;
  logic [15:0]           vel_q, vel_d;

  logic                  last_layer;
  logic                  grant_raw;
  logic                  port_we;
  logic [15:0]           alu_pos;
  logic [15:0]           alu_frame;

  assign last_layer = (layer_q == LAYER_BITS'(NUM_LAYERS - 1));

  layer_update_alu #(
    .VEL_SHIFT (VEL_SHIFT)
  ) u_alu (
    .pos_i   (data_q),
    .vel_i   (vel_q),
    .frame_i (data_q),
    .pos_o   (alu_pos),
    .frame_o (alu_frame)
  );

  // State register and captured read data
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      layer_q <= '0;
      anim_q  <= 1'b0;
      data_q  <= '0;
      vel_q   <= '0;
    end else begin
      state_q <= state_d;
      layer_q <= layer_d;
      anim_q  <= anim_d;
      data_q  <= data_d;
      vel_q   <= vel_d;
    end
  end

  // Next-state logic and header store port drive
  always_comb begin
    state_d            = state_q;
    layer_d            = layer_q;
    anim_d             = anim_q;
    data_d             = data_q;
    vel_d              = vel_q;
    grant_raw          = 1'b0;
    port_we            = 1'b0;
    ctrlReadWriteLayer = layer_q;
    layerRegisterIndex = REG_FLAGS;
    writeLayerData     = '0;

    case (state_q)
      ST_IDLE: begin
        ctrlReadWriteLayer = '0;
        if (frameStart) begin
          state_d = ST_RD_FLAGS;
          layer_d = '0;
        end else if (hostReq) begin
          grant_raw          = 1'b1;
          ctrlReadWriteLayer = hostLayer;
          layerRegisterIndex = hostRegIndex;
          writeLayerData     = hostWriteData;
          port_we            = hostWriteEn;
        end
      end
      ST_RD_FLAGS: begin
        anim_d = ctrlReadData[FLAG_ANIMATED];
        if (ctrlReadData[FLAG_POPULATED] && ctrlReadData[FLAG_SPRITE]) begin
          state_d = ST_RD_XPOS;
        end else if (last_layer) begin
          state_d = ST_DONE;
        end else begin
          layer_d = layer_q + 1'b1;
        end
      end
      ST_RD_XPOS: begin
        layerRegisterIndex = REG_XPOS;
        data_d             = ctrlReadData;
        state_d            = ST_RD_XVEL;
      end
      ST_RD_XVEL: begin
        layerRegisterIndex = REG_XVEL;
        vel_d              = ctrlReadData;
        state_d            = ST_WR_XPOS;
      end
      ST_WR_XPOS: begin
        layerRegisterIndex = REG_XPOS;
        writeLayerData     = alu_pos;
        port_we            = 1'b1;
        state_d            = ST_RD_YPOS;
      end
      ST_RD_YPOS: begin
        layerRegisterIndex = REG_YPOS;
        data_d             = ctrlReadData;
        state_d            = ST_RD_YVEL;
      end
      ST_RD_YVEL: begin
        layerRegisterIndex = REG_YVEL;
        vel_d              = ctrlReadData;
        state_d            = ST_WR_YPOS;
      end
      ST_WR_YPOS: begin
        layerRegisterIndex = REG_YPOS;
        writeLayerData     = alu_pos;
        port_we            = 1'b1;
        if (anim_q) begin
          state_d = ST_RD_FRAME;
        end else if (last_layer) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_FLAGS;
          layer_d = layer_q + 1'b1;
        end
      end
      ST_RD_FRAME: begin
        layerRegisterIndex = REG_FRAME;
        data_d             = ctrlReadData;
        state_d            = ST_WR_FRAME;
      end
      ST_WR_FRAME: begin
        layerRegisterIndex = REG_FRAME;
        writeLayerData     = alu_frame;
        port_we            = 1'b1;
        if (last_layer) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RD_FLAGS;
          layer_d = layer_q + 1'b1;
        end
      end
      ST_DONE: begin
        ctrlReadWriteLayer = '0;
        state_d            = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status and host-side outputs; reset blocks any write or grant in its cycle
  always_comb begin
    busy         = (state_q != ST_IDLE) && (state_q != ST_DONE);
    sweepDone    = (state_q == ST_DONE);
    overrun      = frameStart && busy;
    hostGrant    = grant_raw && reset;
    writeLayerEn = port_we && reset;
    hostReadData = hostGrant ? ctrlReadData : '0;
  end

endmodule

// File: doc/layer_motion_sequencer.md
Name: layer_motion_sequencer

Overview:
Per-frame sequencer that owns the controller port of the layer header store. On each frame start it walks all layers: applies X/Y velocity to position for populated sprite layers, and advances the animation frame for animated sprites. Between sweeps it arbitrates single-cycle host (CPU) register accesses onto the same port, so velocity and animation write-back is done in hardware before pixel processing.

Parameters:
NUM_LAYERS, 32, layers swept per frame (max 32).
LAYER_BITS, 5, width of layer index.
VEL_SHIFT, 6, arithmetic right shift applied to velocity (pixels/second to pixels/frame, ~64 fps).

Ports:
clk  input  1  GPU clock.
reset  input  1  Synchronous, active-low reset (0 = reset).
frameStart  input  1  Single-cycle pulse: begin a sweep.
hostReq  input  1  Host access request; held until hostGrant.
hostWriteEn  input  1  1 = host write, 0 = host read.
hostLayer  input  5  Host target layer.
hostRegIndex  input  3  Host target register index.
hostWriteData  input  16  Host write data.
hostGrant  output  1  Host access performed this cycle.
hostReadData  output  16  Read data; valid when hostGrant=1.
ctrlReadData  input  16  Combinational read data from header store.
ctrlReadWriteLayer  output  5  Layer address to header store.
layerRegisterIndex  output  3  Register index to header store.
writeLayerData  output  16  Write data to header store.
writeLayerEn  output  1  Write strobe to header store.
busy  output  1  Sweep in progress.
sweepDone  output  1  One-cycle pulse on sweep completion.
overrun  output  1  One-cycle pulse: frameStart arrived while busy.

Behaviour:
- Reset: state IDLE, layer counter 0, busy=0, sweepDone=0, overrun=0, hostGrant=0. Port outputs are combinational: IDLE with no grant drives layer 0, index 0, data 0, writeLayerEn=0.
- Header store reads are combinational. Each read state drives address and captures ctrlReadData into a local register at the clock edge. Writes commit at the posedge with writeLayerEn=1.
- States: IDLE, RD_FLAGS, RD_XPOS, RD_XVEL, WR_XPOS, RD_YPOS, RD_YVEL, WR_YPOS, RD_FRAME, WR_FRAME, DONE.
- IDLE: frameStart -> RD_FLAGS with layer=0, busy=1. frameStart has priority over hostReq in the same cycle.
- RD_FLAGS (index 0): if flags[0]=1 and flags[1]=1 (populated sprite) -> RD_XPOS. Otherwise advance layer and stay in RD_FLAGS, or go to DONE after layer NUM_LAYERS-1.
- Hidden layers (flags[2]) are still updated. Text layers are never modified.
- RD_XPOS(3) -> RD_XVEL(5) -> WR_XPOS(3): write Xpos + (Xvel >>> VEL_SHIFT). The sum is 16-bit two's complement and wraps; no saturation.
- RD_YPOS(4) -> RD_YVEL(6) -> WR_YPOS(4): same rule for Y.
- After WR_YPOS: if flags[3]=1 (animated) -> RD_FRAME(7), otherwise next layer or DONE.
- WR_FRAME(7): num = reg7[7:0], cur = reg7[15:8]. nxt = (num<=1 || cur+1>=num) ? 0 : cur+1. Write {nxt, num}; num is preserved.
- Cycles per layer: skipped 1, static sprite 7, animated sprite 9. Worst-case sweep = 9*NUM_LAYERS+1 cycles.
- DONE: sweepDone=1 for one cycle, busy=0, then -> IDLE.
- Host arbitration: hostGrant = hostReq && state==IDLE && !frameStart (combinational). While granted, the port mirrors host signals, writeLayerEn=hostWriteEn, and hostReadData=ctrlReadData. Each grant is exactly one access. Host requests stall (no grant) for the whole sweep.
- frameStart while busy: ignored, overrun pulses one cycle, and the sweep continues unaffected.
- Reset mid-sweep: returns to IDLE next edge. Registers already written keep their new values, and no write occurs in the reset cycle.

Decomposition:
- Shared package layer_header_pkg: register index constants (FLAGS=0, WIDTH=1, HEIGHT=2, XPOS=3, YPOS=4, XVEL=5, YVEL=6, FRAME=7), flag bit positions (POPULATED=0, SPRITE=1, HIDDEN=2, ANIMATED=3), and the state encoding.
- Sub-module layer_update_alu (combinational): position+shifted-velocity adder and frame-advance wrap logic.

Test Plan:
1. Layer 2 = sprite, Xpos=100, Xvel=640, Ypos=50, Yvel=-128, VEL_SHIFT=6; pulse frameStart -> Xpos=110, Ypos=48. All other layers are unpopulated, so sweepDone arrives at cycle 31+7+1 after start.
2. Animated sprite, reg7={cur=4, num=5} -> after sweep reg7={0, 5}. With num=0 or 1 -> cur becomes 0.
3. Xpos=0x7FF0, Xvel=0x0400 (+16 px) -> Xpos=0x8000, wraps to negative. Text layer with nonzero reg5/6 -> all registers unchanged.
4. hostReq write (layer 7, index 3, 0x1234) coincident with frameStart -> no grant that cycle, grant after sweepDone, and the store holds 0x1234. Host read during IDLE returns the stored value with hostGrant=1.
5. frameStart pulsed mid-sweep -> overrun pulses once, and a single sweepDone results. Reset asserted after WR_XPOS of layer 0 -> Xpos updated, Ypos untouched, busy=0 next cycle.
